// File: rtl/score_display.sv
// Binary-to-seven-segment display driver: serial double-dabble (or plain hex shift)
// conversion into DIGITS active-low digits with leading-zero blanking, overflow dashes and blink.
module score_display #(
   parameter int WIDTH     = 8,
   parameter int DIGITS    = 3,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   input  logic                  hex_mode,
   input  logic                  blink_en,
   output logic                  busy,
   output logic                  done,
   output logic [7*DIGITS-1:0]   hex_out
);

   // Decimal digits needed for 2^WIDTH-1 (floor(WIDTH*log10(2))+1); always covers the hex nibbles too.
   localparam int NDEC = (WIDTH * 30103) / 100000 + 1;
   localparam int NACC = (NDEC > DIGITS) ? NDEC : DIGITS;
   localparam int AW   = 4 * NACC;
   localparam int SW   = $clog2(WIDTH + 1);
   localparam int CW   = $clog2(BLINK_DIV);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_LOAD = 2'd2;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0011000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         4'hF:    s = 7'b0001110;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   logic [1:0]          state_r, state_s;
   logic [WIDTH-1:0]    sreg_r, sreg_s;
   logic                hexm_r, hexm_s;
   logic [AW-1:0]       acc_r, acc_s, adj_s;
   logic [SW-1:0]       step_r, step_s;
   logic [4*DIGITS-1:0] disp_r, disp_s;
   logic                ovf_r, ovf_s;
   logic                shown_r, shown_s;
   logic                busy_r, busy_s;
   logic                done_r, done_s;
   logic [CW-1:0]       cnt_r, cnt_s;
   logic                phase_r, phase_s;
   logic [7*DIGITS-1:0] hex_r, hex_s;
   logic                accept_s;
   logic                lead_s;

   // Double-dabble correction: nibbles >= 5 get +3 before the shift (decimal mode only).
   always_comb begin
      adj_s = acc_r;
      for (int i = 0; i < NACC; i++) begin
         if (!hexm_r && (acc_r[4*i +: 4] >= 4'd5)) begin
            adj_s[4*i +: 4] = acc_r[4*i +: 4] + 4'd3;
         end else begin
            adj_s[4*i +: 4] = acc_r[4*i +: 4];
         end
      end
   end

   // Conversion FSM next-state; a new start is taken in IDLE and also in LOAD for back-to-back use.
   always_comb begin
      state_s  = state_r;
      sreg_s   = sreg_r;
      hexm_s   = hexm_r;
      acc_s    = acc_r;
      step_s   = step_r;
      disp_s   = disp_r;
      ovf_s    = ovf_r;
      shown_s  = shown_r;
      done_s   = 1'b0;
      busy_s   = 1'b0;
      accept_s = start && (state_r != ST_CONV);
      case (state_r)
         ST_CONV: begin
            acc_s  = (adj_s << 1) | {{(AW-1){1'b0}}, sreg_r[WIDTH-1]};
            sreg_s = sreg_r << 1;
            step_s = step_r + {{(SW-1){1'b0}}, 1'b1};
            if (step_r == SW'(WIDTH - 1)) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_CONV;
            end
         end
         ST_LOAD: begin
            disp_s  = acc_r[4*DIGITS-1:0];
            ovf_s   = |(acc_r >> (4 * DIGITS));
            shown_s = 1'b1;
            done_s  = 1'b1;
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      if (accept_s) begin
         sreg_s  = value;
         hexm_s  = hex_mode;
         acc_s   = '0;
         step_s  = '0;
         state_s = ST_CONV;
         busy_s  = 1'b1;
      end else begin
         busy_s  = (state_r == ST_CONV);
      end
   end

   // Blink divider: held at zero while disabled so each episode starts visible.
   always_comb begin
      if (!blink_en) begin
         cnt_s   = '0;
         phase_s = 1'b0;
      end else if (cnt_r == CW'(BLINK_DIV - 1)) begin
         cnt_s   = '0;
         phase_s = ~phase_r;
      end else begin
         cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
         phase_s = phase_r;
      end
   end

   // Segment image built from next-state values so the registered output has no extra lag.
   always_comb begin
      lead_s = 1'b1;
      hex_s  = '1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if (!shown_s || phase_s) begin
            hex_s[7*k +: 7] = SEG_BLANK;
         end else if (ovf_s) begin
            hex_s[7*k +: 7] = SEG_DASH;
         end else if (lead_s && (disp_s[4*k +: 4] == 4'd0) && (k != 0)) begin
            hex_s[7*k +: 7] = SEG_BLANK;
         end else begin
            hex_s[7*k +: 7] = seg7(disp_s[4*k +: 4]);
            lead_s          = 1'b0;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
         sreg_r  <= '0;
         hexm_r  <= 1'b0;
         acc_r   <= '0;
         step_r  <= '0;
         disp_r  <= '0;
         ovf_r   <= 1'b0;
         shown_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         cnt_r   <= '0;
         phase_r <= 1'b0;
         hex_r   <= '1;
      end else begin
         state_r <= state_s;
         sreg_r  <= sreg_s;
         hexm_r  <= hexm_s;
         acc_r   <= acc_s;
         step_r  <= step_s;
         disp_r  <= disp_s;
         ovf_r   <= ovf_s;
         shown_r <= shown_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         cnt_r   <= cnt_s;
         phase_r <= phase_s;
         hex_r   <= hex_s;
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign hex_out = hex_r;

endmodule

// File: tb/tb_score_display.sv
// Randomized scoreboard bench for score_display: two instances (3 and 2 digits) share stimulus;
// expected images come from a divide-by-base reference model.
module tb_score_display;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  value = 8'd0;
   logic        hex_mode = 1'b0;
   logic        blink_en = 1'b0;
   logic        busy0, done0, busy1, done1;
   logic [20:0] hex0;
   logic [13:0] hex1;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;

   typedef struct {
      logic [20:0] h0;
      logic [13:0] h1;
      int          due;
   } exp_t;
   exp_t q[$];

   score_display #(.WIDTH(8), .DIGITS(3), .BLINK_DIV(4)) u0 (
      .clk(clk), .resetn(resetn), .start(start), .value(value), .hex_mode(hex_mode),
      .blink_en(blink_en), .busy(busy0), .done(done0), .hex_out(hex0)
   );

   score_display #(.WIDTH(8), .DIGITS(2), .BLINK_DIV(4)) u1 (
      .clk(clk), .resetn(resetn), .start(start), .value(value), .hex_mode(hex_mode),
      .blink_en(blink_en), .busy(busy1), .done(done1), .hex_out(hex1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;   3: return 7'b0110000;
         4: return 7'b0011001;   5: return 7'b0010010;   6: return 7'b0000010;   7: return 7'b1111000;
         8: return 7'b0000000;   9: return 7'b0011000;  10: return 7'b0001000;  11: return 7'b0000011;
        12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;  15: return 7'b0001110;
         default: return 7'b1111111;
      endcase
   endfunction

   // Display image for value v on nd digits: digit i is shown when v >= base^i (digit 0 always).
   function automatic logic [20:0] model(input int v, input bit h, input int nd);
      int base, lim, t, pw;
      logic [20:0] r;
      base = h ? 16 : 10;
      lim  = 1;
      for (int i = 0; i < nd; i++) lim = lim * base;
      r = '1;
      if (v >= lim) begin
         for (int i = 0; i < nd; i++) r[7*i +: 7] = 7'b0111111;
      end else begin
         t  = v;
         pw = 1;
         for (int i = 0; i < nd; i++) begin
            if (i == 0 || v >= pw) r[7*i +: 7] = seg(t % base);
            t  = t / base;
            pw = pw * base;
         end
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Drives a start at the current negedge and returns at the next negedge with start low.
   task automatic issue(input int v, input bit h);
      exp_t e;
      logic [20:0] m1;
      start    = 1'b1;
      value    = v[7:0];
      hex_mode = h;
      e.h0     = model(v, h, 3);
      m1       = model(v, h, 2);
      e.h1     = m1[13:0];
      e.due    = cyc + 10;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Monitor: every done pulse is matched against the oldest expected conversion.
   always @(negedge clk) begin
      if (resetn) begin
         if (done0 || done1) begin
            if (q.size() == 0) begin
               check("unexpected_done", {30'd0, done1, done0}, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("done0", {31'd0, done0}, 32'd1);
               check("done1", {31'd0, done1}, 32'd1);
               check("done_latency", cyc, e.due);
               check("hex_d3", {11'd0, hex0}, {11'd0, e.h0});
               check("hex_d2", {18'd0, hex1}, {18'd0, e.h1});
            end
         end else if (q.size() > 0 && cyc > q[0].due) begin
            check("missing_done", cyc, q[0].due);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      logic [20:0] v205;
      logic [20:0] v205b;
      v205  = model(205, 1'b0, 3);
      v205b = model(205, 1'b0, 2);

      wait_n(3);
      check("rst_busy", {30'd0, busy1, busy0}, 32'd0);
      check("rst_done", {30'd0, done1, done0}, 32'd0);
      check("rst_hex0", {11'd0, hex0}, {11'd0, 21'h1FFFFF});
      check("rst_hex1", {18'd0, hex1}, {18'd0, 14'h3FFF});
      resetn = 1'b1;
      wait_n(2);
      check("post_rst_hex0", {11'd0, hex0}, {11'd0, 21'h1FFFFF});

      // Directed: 205 decimal with busy window.
      issue(205, 1'b0);
      check("busy_during", {31'd0, busy0}, 32'd1);
      wait_n(8);
      check("busy_before_done", {31'd0, busy0}, 32'd1);
      wait_n(1);
      check("busy_after", {31'd0, busy0}, 32'd0);

      issue(0, 1'b0);     wait_n(10);
      issue(8'hAB, 1'b1); wait_n(10);
      issue(150, 1'b0);   wait_n(10);
      issue(99, 1'b0);    wait_n(10);
      issue(255, 1'b1);   wait_n(8);
      issue(255, 1'b0);   wait_n(8);   // back-to-back acceptance
      issue(16, 1'b1);    wait_n(10);

      // Start during conversion is ignored.
      issue(205, 1'b0);
      wait_n(2);
      start = 1'b1; value = 8'd17; hex_mode = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_n(7);

      for (int n = 0; n < 40; n++) begin
         issue($urandom_range(0, 255), 1'($urandom_range(0, 1)));
         wait_n(8);
         wait_n($urandom_range(0, 3));
      end
      wait_n(3);

      // Blink: period of 4 visible / 4 blank, starting visible.
      issue(205, 1'b0);
      wait_n(9);
      blink_en = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if ((((k + 1) / 4) % 2) == 1) begin
            check("blink_off0", {11'd0, hex0}, {11'd0, 21'h1FFFFF});
            check("blink_off1", {18'd0, hex1}, {18'd0, 14'h3FFF});
         end else begin
            check("blink_on0", {11'd0, hex0}, {11'd0, v205});
            check("blink_on1", {18'd0, hex1}, {18'd0, v205b[13:0]});
         end
      end
      blink_en = 1'b0;
      @(negedge clk);
      check("blink_release", {11'd0, hex0}, {11'd0, v205});

      // Reset in the middle of a conversion.
      issue(205, 1'b0);
      wait_n(3);
      resetn = 1'b0;
      #1;
      q.delete();
      check("abort_busy", {31'd0, busy0}, 32'd0);
      check("abort_done", {31'd0, done0}, 32'd0);
      check("abort_hex0", {11'd0, hex0}, {11'd0, 21'h1FFFFF});
      check("abort_hex1", {18'd0, hex1}, {18'd0, 14'h3FFF});
      @(negedge clk);
      resetn = 1'b1;
      wait_n(12);
      check("abort_hex_after", {11'd0, hex0}, {11'd0, 21'h1FFFFF});
      check("abort_queue", q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/score_display.md
# score_display

Parametrised multi-digit seven-segment display block that converts a binary value to decimal (BCD) or hexadecimal digits and drives DIGITS seven-segment outputs. It adds leading-zero blanking, overflow indication and a blink mode. It sits between game logic (score counters, timers) and the board's HEX display pins. It replaces per-digit combinational decoding at the top level.

## Interface
- WIDTH, 8, bit width of the input value (≥ 4).
- DIGITS, 3, number of seven-segment digits driven (≥ 1).
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (≥ 2).
- clk  in  1  system clock; the only clock.
- resetn  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle request to load `value` and `hex_mode`.
- value  in  WIDTH  unsigned binary value to display.
- hex_mode  in  1  1 = hexadecimal digits, 0 = decimal; sampled with `start`.
- blink_en  in  1  1 = flash the whole display; level-sensitive, not sampled by `start`.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the new digits are on the display.
- hex_out  out  7*DIGITS  segment buses; digit 0 (least significant) is at bits [6:0], digit k at [7k+6:7k].

## Operation
- Segment encoding is active-low, bit order g..a (bit 6 = g, bit 0 = a).
- Digit patterns 0–F:
  - 0–7: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000.
  - 8–F: 0000000, 0011000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Blank = 1111111. Dash = 0111111.
- FSM has three states: IDLE, CONV, LOAD.
  - IDLE: on `start`=1, capture `value` into the shift register, capture `hex_mode`, clear the digit accumulator and step counter, then go to CONV.
  - CONV: runs exactly WIDTH steps, one per cycle.
    - Decimal mode: before each shift, add 3 to every accumulator nibble that is ≥ 5 (double-dabble). Then shift the MSB of the shift register into the accumulator LSB.
    - Hex mode: plain shift, no adjustment.
    - The accumulator is wide enough to hold the full result: ceil(WIDTH/4) nibbles in hex mode, enough BCD digits for 2^WIDTH−1 in decimal mode.
  - After step WIDTH, go to LOAD.
  - LOAD: copy the low DIGITS nibbles into the display registers and compute the overflow flag, pulse `done`, return to IDLE.
- Overflow is set when any accumulator nibble above DIGITS−1 is nonzero. On overflow every digit shows Dash. In hex mode this means value ≥ 16^DIGITS; in decimal mode it means value ≥ 10^DIGITS.
- Leading-zero blanking: every digit above the most significant nonzero digit shows Blank. Digit 0 is never blanked by this rule, so value 0 shows "0". Applies in both modes; not applied when overflow is set.
- Blink:
  - While `blink_en`=1, a counter runs 0..BLINK_DIV−1 and toggles `phase` on each wrap. While `phase`=1, all digits show Blank, and this overrides Dash.
  - While `blink_en`=0, the counter and `phase` are held at 0, so each blink episode starts with a full visible half-period.
- `start` while `busy`=1 is ignored; the captured operands do not change.
- `hex_out` is a function of registered state only; there is no combinational path from any input to `hex_out`.
- The display registers keep the previous value throughout CONV, so the old number stays visible without flicker.

## Timing
- Reset values: `busy`=0, `done`=0, all digits Blank (`hex_out` all ones), overflow=0, blink counter=0, `phase`=0, FSM in IDLE.
- Edge E0 samples `start`=1. `busy`=1 from E0 to E(WIDTH+1).
- At E(WIDTH+1): `hex_out` shows the new value, `done`=1 for exactly one cycle, `busy`=0.
- Latency from `start` to `done` is WIDTH+1 cycles, the same in both modes.
- `start` may be accepted again in the same cycle that `done` is high, i.e. sampled at E(WIDTH+1), giving back-to-back throughput of one conversion per WIDTH+1 cycles.
- Blink with BLINK_DIV=N: `blink_en` rises before edge Ej. The display stays visible for N cycles, then is blank for N cycles, repeating. It is visible in the cycle after `blink_en` falls.
- Reset asserted mid-conversion aborts immediately, with no `done` pulse. All outputs go to their reset values asynchronously.

## Test plan
- Configuration WIDTH=8, DIGITS=3, decimal mode, `start` with value=205: `done` arrives exactly 9 cycles later.
  - `hex_out[6:0]` = 0010010 (5), `[13:7]` = 1000000 (0), `[20:14]` = 0100100 (2).
- Value 0 in decimal mode: digit 0 = 1000000; digits 1 and 2 = 1111111.
- Hex mode, value 8'hAB: digit 0 = 0000011 (b), digit 1 = 0001000 (A), digit 2 = 1111111.
- Configuration DIGITS=2, decimal mode, value 150: all digits = 0111111. Then value 99: both digits = 0011000.
- BLINK_DIV=4, `blink_en`=1 with 205 displayed: 4 cycles showing 205, 4 cycles all 1111111, repeating. Drop `blink_en`: 205 reappears in the next cycle.
- During the conversion of 205:
  - Pulse `start` with value=17 at cycle 3 after the first start: it is ignored, and the display shows 205.
  - In a second run, assert `resetn`=0 at cycle 4: `busy`=0, no `done`, and all digits go to 1111111.
